// File: rtl/button_conditioner.sv
// Button conditioner: input synchronizer, four-state debounce FSM with
// registered level and strobe outputs, and a saturating hold timer that
// raises a single long-press strobe per accepted press.
module button_conditioner #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst_ext,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    // The debounce counter stops one short of the full count: the sample that
    // arrives with the counter at DB_LAST is the last of the stable run.
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_ZERO  = DB_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic                   rst_meta_q;
    logic                   rst_int_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;

    state_t                 state_q,   state_d;
    logic [DB_W-1:0]        db_cnt_q,  db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   level_q,   level_d;
    logic                   press_q,   press_d;
    logic                   release_q, release_d;
    logic                   long_q,    long_d;

    // Reset synchronizer: assert internal reset at once, release it on the second clean edge.
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) begin
            rst_meta_q <= 1'b1;
            rst_int_q  <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_int_q  <= rst_meta_q;
        end
    end

    // Metastability chain: the only logic that ever looks at btn_raw.
    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst_int_q) begin
        if (rst_int_q) begin
            state_q    <= IDLE;
            db_cnt_q   <= DB_ZERO;
            hold_cnt_q <= HOLD_ZERO;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    // Next-state logic: debounce transitions plus the hold timer that keeps
    // running across release bounces while the button is logically down.
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        if ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
            if (hold_cnt_q == HOLD_ARM) begin
                long_d = 1'b1;
            end else begin
                long_d = 1'b0;
            end
        end else begin
            hold_cnt_d = hold_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = PRESSED;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    hold_cnt_d = HOLD_ZERO;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DB_ZERO;
                end else begin
                    state_d  = PRESSED;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    assign btn_level        = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios followed by random button
// activity, every cycle compared against a window-based behavioural model.
module tb_button_conditioner;

    localparam int S = 2;
    localparam int D = 4;
    localparam int L = 10;

    logic clk;
    logic rst_ext;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    int errors = 0;
    int checks = 0;

    // model state
    bit hist_q[$];      // raw samples as seen by the first sync flop
    bit win_q[$];       // last D+1 synchronized samples since reset
    bit lvl = 1'b0;
    int press_edge = -1000;
    int since_fall = 0;
    int edge_cnt = 0;
    logic [3:0] exp_v = 4'b0000;

    // observation counters for directed scenarios
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int last_press = -1;
    int last_release = -1;
    int last_long = -1;

    button_conditioner #(
        .SYNC_STAGES      (S),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .clk             (clk),
        .rst_ext         (rst_ext),
        .btn_raw         (btn_raw),
        .btn_level       (btn_level),
        .press_pulse     (press_pulse),
        .release_pulse   (release_pulse),
        .long_press_pulse(long_press_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clear_obs();
        n_press = 0; n_release = 0; n_long = 0;
        last_press = -1; last_release = -1; last_long = -1;
    endtask

    // Model of one clock edge: the level flips when the last D+1 synchronized
    // samples since reset all disagree with it; long press lands L edges after
    // the press edge provided the button was still logically down before it.
    task automatic model_edge(input bit raw);
        bit rin;
        bit s;
        bit lvl_before;
        bit all_flip;
        rin = rst_ext || (since_fall < 2);
        if (!rst_ext && since_fall < 100) since_fall++;
        exp_v = 4'b0000;
        if (rin) begin
            hist_q.delete();
            for (int i = 0; i < S; i++) hist_q.push_back(1'b0);
            win_q.delete();
            lvl = 1'b0;
            press_edge = -1000;
        end else begin
            s = hist_q[hist_q.size() - S];
            hist_q.push_back(raw);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            win_q.push_back(s);
            if (win_q.size() > D + 1) void'(win_q.pop_front());
            lvl_before = lvl;
            all_flip = (win_q.size() == D + 1);
            foreach (win_q[i]) if (win_q[i] == lvl) all_flip = 1'b0;
            if (all_flip) begin
                lvl = !lvl;
                if (lvl) begin
                    exp_v[2] = 1'b1;
                    press_edge = edge_cnt;
                end else begin
                    exp_v[1] = 1'b1;
                end
            end
            if (lvl_before && (edge_cnt - press_edge == L)) exp_v[0] = 1'b1;
            exp_v[3] = lvl;
        end
    endtask

    task automatic step(input bit raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk("cycle", {btn_level, press_pulse, release_pulse, long_press_pulse}, exp_v);
        if (press_pulse === 1'b1)      begin n_press++;   last_press = edge_cnt;   end
        if (release_pulse === 1'b1)    begin n_release++; last_release = edge_cnt; end
        if (long_press_pulse === 1'b1) begin n_long++;    last_long = edge_cnt;    end
        edge_cnt++;
    endtask

    task automatic steps(input bit raw, input int n);
        for (int i = 0; i < n; i++) step(raw);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_ext = 1'b1;
        since_fall = 0;
        lvl = 1'b0;
        win_q.delete();
        press_edge = -1000;
        #1;
        chk("reset_immediate", {btn_level, press_pulse, release_pulse, long_press_pulse}, 4'b0000);
    endtask

    initial begin
        int t0;
        int seg;
        bit rv;
        rst_ext = 1'b1;
        btn_raw = 1'b0;
        for (int i = 0; i < S; i++) hist_q.push_back(1'b0);

        // reset state
        steps(1'b0, 3);
        rst_ext = 1'b0;
        steps(1'b0, 6);

        // clean press held 20 cycles
        clear_obs();
        t0 = edge_cnt;
        steps(1'b1, 20);
        chk_int("clean_press_count", n_press, 1);
        chk_int("clean_press_time", last_press - t0, S + D);
        chk_int("clean_long_count", n_long, 1);
        chk_int("clean_long_after_press", last_long - last_press, L);

        // release bounce then real release
        clear_obs();
        steps(1'b0, 2);
        steps(1'b1, 4);
        chk_int("release_bounce_rejected", n_release, 0);
        t0 = edge_cnt;
        steps(1'b0, 10);
        chk_int("release_count", n_release, 1);
        chk_int("release_time", last_release - t0, S + D);
        chk("released_level", {btn_level, 3'b000}, 4'b0000);

        // bounce reject
        clear_obs();
        for (int r = 0; r < 5; r++) begin
            steps(1'b1, 3);
            steps(1'b0, 1);
        end
        steps(1'b0, 6);
        chk_int("bounce_press_count", n_press, 0);
        chk_int("bounce_release_count", n_release, 0);

        // short press
        clear_obs();
        t0 = edge_cnt;
        steps(1'b1, 6);
        steps(1'b0, 14);
        chk_int("short_press_count", n_press, 1);
        chk_int("short_release_count", n_release, 1);
        chk_int("short_long_count", n_long, 0);
        chk_int("short_press_time", last_press - t0, S + D);

        // reset while pressed, button held through reset release
        clear_obs();
        steps(1'b1, 8);
        chk_int("pre_reset_press", n_press, 1);
        assert_reset();
        steps(1'b1, 3);
        rst_ext = 1'b0;
        t0 = edge_cnt;
        clear_obs();
        steps(1'b1, 14);
        chk_int("post_reset_press_count", n_press, 1);
        chk_int("post_reset_press_time", last_press - t0, 2 + S + D);
        chk_int("post_reset_release_count", n_release, 0);

        // random activity with occasional resets
        for (int k = 0; k < 120; k++) begin
            rv = 1'($urandom_range(0, 1));
            seg = (rv) ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 9));
            steps(rv, seg);
            if ($urandom_range(0, 29) == 0) begin
                assert_reset();
                steps(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
                rst_ext = 1'b0;
            end
        end
        steps(1'b0, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have a parameter SYNC_STAGES, default 2, giving the number of input synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have a parameter DEBOUNCE_CYCLES, default 500000, giving the consecutive stable samples needed to accept a level change (legal range >= 1).
REQ-003 The block SHALL have a parameter LONG_PRESS_CYCLES, default 50000000, giving the hold time counted from press acceptance (legal range > DEBOUNCE_CYCLES).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 The block SHALL have port rst_ext, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port btn_raw, input, 1 bit: asynchronous mechanical pushbutton, active-high, may bounce.
REQ-007 The block SHALL have port btn_level, output, 1 bit: debounced button level, registered.
REQ-008 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe on accepted press.
REQ-009 The block SHALL have port release_pulse, output, 1 bit: one-cycle strobe on accepted release.
REQ-010 The block SHALL have port long_press_pulse, output, 1 bit: one-cycle strobe when a press has been held LONG_PRESS_CYCLES.

Function
REQ-011 btn_raw SHALL pass through a SYNC_STAGES-deep flop chain, giving btn_sync; no other logic may sample btn_raw.
REQ-012 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-013 In IDLE with btn_sync=1, the FSM SHALL go to PRESS_WAIT and clear the debounce counter.
REQ-014 In PRESS_WAIT with btn_sync=0, the FSM SHALL return to IDLE with no output activity, as a bounce reject.
REQ-015 In PRESS_WAIT with btn_sync=1 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL go to PRESSED, set btn_level=1, pulse press_pulse for one cycle and clear the hold counter.
REQ-016 In PRESSED with btn_sync=0, the FSM SHALL go to RELEASE_WAIT and clear the debounce counter.
REQ-017 In RELEASE_WAIT with btn_sync=1, the FSM SHALL return to PRESSED; the hold counter SHALL continue and SHALL NOT clear.
REQ-018 In RELEASE_WAIT with btn_sync=0 for DEBOUNCE_CYCLES consecutive cycles, the FSM SHALL go to IDLE, set btn_level=0 and pulse release_pulse for one cycle.
REQ-019 Latency from the first clk edge sampling a clean btn_raw change to the btn_level change SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles; strobes SHALL coincide with the btn_level change.
REQ-020 The hold counter SHALL increment every cycle in PRESSED and RELEASE_WAIT, and SHALL saturate at LONG_PRESS_CYCLES.
REQ-021 long_press_pulse SHALL fire exactly once per accepted press, in the cycle the hold counter reaches LONG_PRESS_CYCLES, whether the FSM is in PRESSED or RELEASE_WAIT.
REQ-022 If the release is accepted before LONG_PRESS_CYCLES, no long_press_pulse SHALL occur for that press.
REQ-023 Counter widths SHALL be $clog2(param+1); counters SHALL never wrap.
REQ-024 At most one of press_pulse and release_pulse SHALL be high in any cycle.
REQ-025 long_press_pulse SHALL never coincide with press_pulse.

Reset
REQ-026 rst_ext SHALL feed a 2-flop reset synchronizer: assert internal reset asynchronously, deassert it synchronously two clk edges after rst_ext falls.
REQ-027 While internal reset is asserted, the FSM SHALL be IDLE, all counters and sync flops SHALL be 0, and all four outputs SHALL be 0.
REQ-028 On reset assertion mid-operation, including in PRESSED, the outputs SHALL clear immediately with no release_pulse.
REQ-029 If the button is held through reset release, it SHALL be treated as a new press: press_pulse after the full REQ-019 latency.

Verification
Benches SHALL use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
REQ-030 Clean press: btn_raw 0->1 held 20 cycles -> press_pulse for one cycle and btn_level=1 exactly 6 cycles after the sampling edge; long_press_pulse once, 10 cycles after press_pulse.
REQ-031 Bounce reject: btn_raw high 3 cycles, low, repeated 5 times -> no strobes and btn_level stays 0.
REQ-032 Release bounce: in PRESSED, btn_raw low 2 cycles then high -> no release_pulse; then low 10 cycles -> release_pulse, with btn_level=0 6 cycles after the final fall.
REQ-033 Short press: btn_raw high 6 cycles then low -> press_pulse and release_pulse each once; long_press_pulse never fires.
REQ-034 Reset mid-press: assert rst_ext while in PRESSED -> all outputs 0 immediately, no release_pulse; btn_raw still high at release -> press_pulse 6 cycles after internal reset deasserts.
